fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Read-side consumer of the synchronous FIFO. It pops words from the FIFO's first-word-fall-through output, where read data is valid whenever fifo_empty is low. Each word is serialized as an asynchronous UART frame: start bit, data bits LSB first, optional parity bit, then stop bit(s). The block sits directly downstream of the FIFO and drives the chip's serial TX pin.

Parameters:
DATA_WIDTH, 8, width of a FIFO word and number of data bits per frame
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 or more
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits starting new frames; a frame already in progress always completes
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO head word; valid when fifo_empty=0
fifo_rd  output  1  pop strobe to the FIFO; combinational; high for exactly one cycle per word
tx  output  1  serial line; idles high
busy  output  1  high while a frame is in progress (state != IDLE)
frame_done  output  1  registered one-cycle pulse after each frame completes

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, tx=1, busy=0, frame_done=0, fifo_rd=0.
  - Baud counter, bit index and shift register are cleared.
  - A frame in progress is abandoned. Its word was already popped and is lost.
- Pop rule:
  - fifo_rd = enable & ~fifo_empty & (state==IDLE | end_of_frame).
  - end_of_frame is the final clk of the last stop bit.
  - On the edge where fifo_rd=1, fifo_data is captured into the shift register and the FSM enters START.
  - fifo_rd never asserts while fifo_empty=1, so the FIFO underflow flag is never set by this block.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
  - IDLE: tx=1; stays until the pop rule fires.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then the register shifts right. After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: tx = ^data for even parity, ~^data for odd parity, held CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of frame:
  - If the pop rule fires on end_of_frame, go straight to START. There is no idle gap, so back-to-back frames are contiguous.
  - Otherwise go to IDLE.
- Timing:
  - tx is registered. The first START cycle on tx is the cycle after the pop edge.
  - Frame length = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles exactly.
- Counters:
  - Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit index width is $clog2(DATA_WIDTH+1).
  - Neither counter may run while in IDLE.
- frame_done: asserted for one cycle on the cycle after end_of_frame, including frames that chain back-to-back.
- Simultaneous events:
  - enable falling mid-frame: the current frame completes and no further pop occurs.
  - enable falling on the end_of_frame cycle: no pop, go to IDLE.
  - FIFO becomes non-empty on the end_of_frame cycle: pop and chain.
- fifo_data changing mid-frame has no effect; only the captured copy is transmitted.

Test Plan:
1. Reset and idle: assert rst_n=0 mid-frame -> tx=1, busy=0, fifo_rd=0 immediately. With enable=1 and fifo_empty=1 for 100 cycles -> fifo_rd never asserts and tx stays 1.
2. Single word (DATA_WIDTH=8, CLKS_PER_BIT=4, 8N1): push 0xA5 and enable -> one fifo_rd pulse, then 40 tx cycles of 0 | 1,0,1,0,0,1,0,1 | 1 (each bit 4 cycles). frame_done pulses once; busy is high for exactly 40 cycles.
3. Back-to-back: FIFO holds 0x00, 0xFF, 0x3C -> 3 fifo_rd pulses spaced exactly 40 cycles apart. The line has no idle gap between frames, frame_done pulses 3 times, and the FIFO ends empty.
4. Parity: PARITY_EN=1, word 0xA5 -> parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1. Word 0x01 -> parity bit 1 (even) and 0 (odd). Frame length is 44 cycles.
5. Enable drop: deassert enable during DATA of the first of 2 queued words -> the first frame completes intact and the second word is not popped (fifo_empty stays 0). Re-assert enable -> the second word is popped within 1 cycle.
6. STOP_BITS=2 with CLKS_PER_BIT=3: word 0x5A -> stop high for 6 cycles, 33-cycle frame. A chained second frame's start bit follows immediately after the 6th stop cycle.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between the synchronous FIFO and its UART transmitter.
`timescale 1ns/1ps
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd;

  // Reader side: samples the FWFT head and issues pops.
  modport master (input fifo_empty, input fifo_data, output fifo_rd);
  // FIFO side: presents the head word and consumes pops.
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a FWFT FIFO and frames them on tx.
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q;
  logic                  done_q;

  logic bit_end;
  logic end_of_frame;
  logic pop;

  // Frame timing strobes and the FWFT pop decision.
  always_comb begin
    bit_end      = (baud_q == CW'(CLKS_PER_BIT - 1));
    end_of_frame = (state_q == STOP) && bit_end && (bit_q == BW'(STOP_BITS - 1));
    // Gated by rst_n so no word is popped while the capture registers are held.
    pop          = rst_n && enable && !fifo.fifo_empty &&
                   ((state_q == IDLE) || end_of_frame);
  end

  // Next-state, counters, shift register and registered-tx precompute.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // A pop overrides the frame tail so chained frames start with no gap.
    if (pop) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = DATA_WIDTH'(fifo.fifo_data);
      par_d   = ^fifo.fifo_data;
    end

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d ^ (PARITY_ODD != 0);
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= end_of_frame;
    end
  end

  assign fifo.fifo_rd = pop;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: four configurations of fifo_uart_tx fed by small FIFO models.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] en;
  logic [3:0] tx_w, busy_w, fd_w, rd_w;

  logic [7:0] mem [4][16];
  logic [3:0] wp [4];
  logic [3:0] rp [4] = '{default: 4'd0};
  logic       underflow = 1'b0;

  int total = 0;
  int bad   = 0;

  logic exp_q[$];
  logic got_q[$];
  int   rd_pos[$];

  always #5 clk = ~clk;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) f0 ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) f1 ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) f2 ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) f3 ();

  assign f0.fifo_empty = (wp[0] == rp[0]);
  assign f1.fifo_empty = (wp[1] == rp[1]);
  assign f2.fifo_empty = (wp[2] == rp[2]);
  assign f3.fifo_empty = (wp[3] == rp[3]);
  assign f0.fifo_data  = mem[0][rp[0]];
  assign f1.fifo_data  = mem[1][rp[1]];
  assign f2.fifo_data  = mem[2][rp[2]];
  assign f3.fifo_data  = mem[3][rp[3]];
  assign rd_w = {f3.fifo_rd, f2.fifo_rd, f1.fifo_rd, f0.fifo_rd};

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .fifo(f0),
    .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .fifo(f1),
    .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(en[2]), .fifo(f2),
    .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(3), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .enable(en[3]), .fifo(f3),
    .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(fd_w[3]));

  // FIFO read pointers advance on each pop; a pop from an empty FIFO is flagged.
  always @(posedge clk) begin
    if (f0.fifo_rd) begin if (wp[0] == rp[0]) underflow <= 1'b1; rp[0] <= rp[0] + 4'd1; end
    if (f1.fifo_rd) begin if (wp[1] == rp[1]) underflow <= 1'b1; rp[1] <= rp[1] + 4'd1; end
    if (f2.fifo_rd) begin if (wp[2] == rp[2]) underflow <= 1'b1; rp[2] <= rp[2] + 4'd1; end
    if (f3.fifo_rd) begin if (wp[3] == rp[3]) underflow <= 1'b1; rp[3] <= rp[3] + 4'd1; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] w);
    mem[i][wp[i]] = w;
    wp[i] = wp[i] + 4'd1;
  endtask

  // Appends the expected per-cycle tx waveform of one frame.
  task automatic add_frame(input logic [7:0] w, input int cpb, input bit pe,
                           input bit odd, input int stops);
    repeat (cpb) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) repeat (cpb) exp_q.push_back(w[b]);
    if (pe) repeat (cpb) exp_q.push_back((^w) ^ odd);
    repeat (stops * cpb) exp_q.push_back(1'b1);
  endtask

  // Samples one DUT for the expected waveform plus one trailing idle cycle.
  task automatic observe(input int i, input int drop_at, output int mism,
                         output int busy_n, output int fd_n, output int rd_n);
    mism = 0; busy_n = 0; fd_n = 0; rd_n = 0;
    got_q.delete();
    rd_pos.delete();
    for (int c = 0; c < exp_q.size() + 1; c++) begin
      logic e;
      e = (c < exp_q.size()) ? exp_q[c] : 1'b1;
      @(negedge clk);
      got_q.push_back(tx_w[i]);
      if (tx_w[i] !== e) mism++;
      if (busy_w[i]) busy_n++;
      if (fd_w[i]) fd_n++;
      if (rd_w[i]) begin rd_n++; rd_pos.push_back(c); end
      if (c == drop_at) en[i] = 1'b0;
    end
  endtask

  int mism, busy_n, fd_n, rd_n, viol;

  initial begin
    for (int i = 0; i < 4; i++) wp[i] = 4'd0;
    rst_n = 1'b0;
    en    = 4'h0;
    repeat (3) @(negedge clk);
    check("reset tx",   32'(tx_w),   32'hF);
    check("reset busy", 32'(busy_w), 32'h0);
    check("reset done", 32'(fd_w),   32'h0);
    check("reset rd",   32'(rd_w),   32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a frame.
    en = 4'hF;
    push(0, 8'h33);
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("midframe busy", 32'(busy_w[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst tx",   32'(tx_w[0]),   32'd1);
    check("async rst busy", 32'(busy_w[0]), 32'd0);
    check("async rst rd",   32'(rd_w[0]),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rd_w[0] !== 1'b0 || tx_w[0] !== 1'b1) viol++;
    end
    check("idle 100 cycles", 32'(viol), 32'd0);

    // Single 8N1 word.
    push(0, 8'hA5);
    #1;
    check("single rd", 32'(rd_w[0]), 32'd1);
    exp_q.delete();
    add_frame(8'hA5, 4, 1'b0, 1'b0, 1);
    observe(0, -1, mism, busy_n, fd_n, rd_n);
    check("single tx wave",  32'(mism),   32'd0);
    check("single busy len", 32'(busy_n), 32'd40);
    check("single done",     32'(fd_n),   32'd1);
    check("single extra rd", 32'(rd_n),   32'd0);
    check("single bit2",     32'(got_q[3*4+1]), 32'd1);
    check("single bit1",     32'(got_q[2*4+1]), 32'd0);

    // Back-to-back frames.
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
    #1;
    check("b2b first rd", 32'(rd_w[0]), 32'd1);
    exp_q.delete();
    add_frame(8'h00, 4, 1'b0, 1'b0, 1);
    add_frame(8'hFF, 4, 1'b0, 1'b0, 1);
    add_frame(8'h3C, 4, 1'b0, 1'b0, 1);
    observe(0, -1, mism, busy_n, fd_n, rd_n);
    check("b2b tx wave",  32'(mism),   32'd0);
    check("b2b busy len", 32'(busy_n), 32'd120);
    check("b2b done",     32'(fd_n),   32'd3);
    check("b2b rd count", 32'(rd_n),   32'd2);
    check("b2b rd pos1",  32'((rd_pos.size() > 0) ? rd_pos[0] : -1), 32'd39);
    check("b2b rd pos2",  32'((rd_pos.size() > 1) ? rd_pos[1] : -1), 32'd79);
    check("b2b empty",    32'(f0.fifo_empty), 32'd1);

    // Parity, even then odd, two words each.
    push(1, 8'hA5);
    exp_q.delete();
    add_frame(8'hA5, 4, 1'b1, 1'b0, 1);
    observe(1, -1, mism, busy_n, fd_n, rd_n);
    check("even A5 wave",  32'(mism),   32'd0);
    check("even A5 len",   32'(busy_n), 32'd44);
    check("even A5 par",   32'(got_q[9*4+1]), 32'd0);
    push(1, 8'h01);
    exp_q.delete();
    add_frame(8'h01, 4, 1'b1, 1'b0, 1);
    observe(1, -1, mism, busy_n, fd_n, rd_n);
    check("even 01 wave",  32'(mism), 32'd0);
    check("even 01 par",   32'(got_q[9*4+1]), 32'd1);
    push(2, 8'hA5);
    exp_q.delete();
    add_frame(8'hA5, 4, 1'b1, 1'b1, 1);
    observe(2, -1, mism, busy_n, fd_n, rd_n);
    check("odd A5 wave",   32'(mism),   32'd0);
    check("odd A5 len",    32'(busy_n), 32'd44);
    check("odd A5 par",    32'(got_q[9*4+1]), 32'd1);
    push(2, 8'h01);
    exp_q.delete();
    add_frame(8'h01, 4, 1'b1, 1'b1, 1);
    observe(2, -1, mism, busy_n, fd_n, rd_n);
    check("odd 01 wave",   32'(mism), 32'd0);
    check("odd 01 par",    32'(got_q[9*4+1]), 32'd0);

    // Enable drops during DATA of the first of two queued words.
    push(0, 8'h81); push(0, 8'h42);
    exp_q.delete();
    add_frame(8'h81, 4, 1'b0, 1'b0, 1);
    observe(0, 10, mism, busy_n, fd_n, rd_n);
    check("drop tx wave", 32'(mism),   32'd0);
    check("drop len",     32'(busy_n), 32'd40);
    check("drop done",    32'(fd_n),   32'd1);
    check("drop no pop",  32'(rd_n),   32'd0);
    repeat (3) @(negedge clk);
    check("drop not empty", 32'(f0.fifo_empty), 32'd0);
    check("drop idle",      32'(busy_w[0]),     32'd0);
    en[0] = 1'b1;
    #1;
    check("reenable rd", 32'(rd_w[0]), 32'd1);
    exp_q.delete();
    add_frame(8'h42, 4, 1'b0, 1'b0, 1);
    observe(0, -1, mism, busy_n, fd_n, rd_n);
    check("reenable wave", 32'(mism), 32'd0);
    check("reenable empty", 32'(f0.fifo_empty), 32'd1);

    // Two stop bits, CLKS_PER_BIT=3, chained.
    push(3, 8'h5A); push(3, 8'h11);
    exp_q.delete();
    add_frame(8'h5A, 3, 1'b0, 1'b0, 2);
    add_frame(8'h11, 3, 1'b0, 1'b0, 2);
    observe(3, -1, mism, busy_n, fd_n, rd_n);
    check("stop2 wave",   32'(mism),   32'd0);
    check("stop2 len",    32'(busy_n), 32'd66);
    check("stop2 done",   32'(fd_n),   32'd2);
    check("stop2 rd pos", 32'((rd_pos.size() > 0) ? rd_pos[0] : -1), 32'd32);
    check("stop2 last stop", 32'(got_q[32]), 32'd1);
    check("stop2 chain start", 32'(got_q[33]), 32'd0);

    check("no underflow", 32'(underflow), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
